// File: rtl/sprite_pkg.sv
// Shared sprite data for the compositor: 16x8 bitmaps, palette and projectile size.
// Bitmap rows are stored MSB-first, so bit 15 of a row is the leftmost pixel.
package sprite_pkg;

  localparam int SPR_W  = 16;
  localparam int SPR_H  = 8;
  localparam int PROJ_W = 2;
  localparam int PROJ_H = 8;

  localparam logic [7:0] GREEN = 8'h1C;
  localparam logic [7:0] WHITE = 8'hFF;
  localparam logic [7:0] RED   = 8'hE0;

  localparam logic [15:0] PLAYER [8] = '{
    16'b0000000110000000,
    16'b0000001111000000,
    16'b0000001111000000,
    16'b0111111111111110,
    16'b1111111111111111,
    16'b1111111111111111,
    16'b1111111111111111,
    16'b1111111111111111
  };

  localparam logic [15:0] INVADER [8] = '{
    16'b1100000000000011,
    16'b0011000000001100,
    16'b0011111111111100,
    16'b1111001111001111,
    16'b1111111111111111,
    16'b0011111111111100,
    16'b0011000000001100,
    16'b1100000000000011
  };

  typedef enum logic [0:0] {SPR_PLAYER, SPR_INVADER} sprite_e;

  function automatic logic sprite_bit(input sprite_e sel, input logic [2:0] row,
                                      input logic [3:0] col);
    logic [15:0] line;
    line = (sel == SPR_PLAYER) ? PLAYER[row] : INVADER[row];
    return line[4'd15 - col];
  endfunction

endpackage

// File: rtl/proj_hit_unit.sv
// Per-slot projectile rectangle test; splits hits into player lasers and invader missiles.
module proj_hit_unit
  import sprite_pkg::*;
#(
  parameter int NUM_PROJ = 4
) (
  input  logic [9:0]            i_px,
  input  logic [9:0]            i_py,
  input  logic [NUM_PROJ-1:0]   i_active,
  input  logic [NUM_PROJ-1:0]   i_owner,
  input  logic [NUM_PROJ*10-1:0] i_proj_x,
  input  logic [NUM_PROJ*10-1:0] i_proj_y,
  output logic [NUM_PROJ-1:0]   o_laser,
  output logic [NUM_PROJ-1:0]   o_missile
);

  for (genvar k = 0; k < NUM_PROJ; k++) begin : g_slot
    logic [10:0] w_x0, w_y0, w_x1, w_y1;
    logic        w_in;

    // 11-bit bounds so a rectangle reaching past 1023 clips instead of wrapping
    assign w_x0 = {1'b0, i_proj_x[10*k +: 10]};
    assign w_y0 = {1'b0, i_proj_y[10*k +: 10]};
    assign w_x1 = w_x0 + 11'(PROJ_W - 1);
    assign w_y1 = w_y0 + 11'(PROJ_H - 1);
    assign w_in = i_active[k] &&
                  ({1'b0, i_px} >= w_x0) && ({1'b0, i_px} <= w_x1) &&
                  ({1'b0, i_py} >= w_y0) && ({1'b0, i_py} <= w_y1);
    assign o_laser[k]   = w_in && !i_owner[k];
    assign o_missile[k] = w_in &&  i_owner[k];
  end

endmodule

// File: rtl/sprite_compositor.sv
// Two-stage layered pixel compositor (player, missiles, lasers, invader grid) with
// per-frame collision accumulation and a valid/ack report to the game FSM.
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int ROWS         = 5,
  parameter int COLS         = 11,
  parameter int NUM_PROJ     = 4,
  parameter int SCALE_LOG2   = 1,
  parameter int PITCH_X_LOG2 = 5,
  parameter int PITCH_Y_LOG2 = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [9:0]             px,
  input  logic [9:0]             py,
  input  logic                   de,
  input  logic                   frame,
  input  logic [9:0]             player_x,
  input  logic [9:0]             player_y,
  input  logic [ROWS*COLS-1:0]   invaders,
  input  logic [9:0]             invaders_x,
  input  logic [9:0]             invaders_y,
  input  logic [NUM_PROJ-1:0]    proj_active,
  input  logic [NUM_PROJ-1:0]    proj_owner,
  input  logic [NUM_PROJ*10-1:0] proj_x,
  input  logic [NUM_PROJ*10-1:0] proj_y,
  output logic [7:0]             vga_out,
  output logic                   hit_valid,
  input  logic                   hit_ack,
  output logic                   inv_hit,
  output logic [2:0]             hit_row,
  output logic [3:0]             hit_col,
  output logic [2:0]             hit_proj,
  output logic                   player_hit,
  output logic                   hit_overrun
);

  localparam int          NI     = ROWS * COLS;
  localparam logic [10:0] SPR_WS = 11'(SPR_W << SCALE_LOG2);
  localparam logic [10:0] SPR_HS = 11'(SPR_H << SCALE_LOG2);
  localparam logic [10:0] MASK_X = 11'((1 << PITCH_X_LOG2) - 1);
  localparam logic [10:0] MASK_Y = 11'((1 << PITCH_Y_LOG2) - 1);

  logic [10:0] w_px, w_py, w_pdx, w_pdy, w_idx, w_idy, w_col, w_row, w_ox, w_oy;
  logic [3:0]  w_pbx, w_ibx;
  logic [2:0]  w_pby, w_iby;
  logic        w_ply_in, w_inv_in;
  logic [NUM_PROJ-1:0] w_laser, w_missile;

  assign w_px  = {1'b0, px};
  assign w_py  = {1'b0, py};
  assign w_pdx = w_px - {1'b0, player_x};
  assign w_pdy = w_py - {1'b0, player_y};
  assign w_ply_in = (w_px >= {1'b0, player_x}) && (w_py >= {1'b0, player_y}) &&
                    (w_pdx < SPR_WS) && (w_pdy < SPR_HS);
  assign w_pbx = 4'(w_pdx >> SCALE_LOG2);
  assign w_pby = 3'(w_pdy >> SCALE_LOG2);

  assign w_idx = w_px - {1'b0, invaders_x};
  assign w_idy = w_py - {1'b0, invaders_y};
  assign w_col = w_idx >> PITCH_X_LOG2;
  assign w_row = w_idy >> PITCH_Y_LOG2;
  assign w_ox  = w_idx & MASK_X;
  assign w_oy  = w_idy & MASK_Y;
  assign w_inv_in = (w_px >= {1'b0, invaders_x}) && (w_py >= {1'b0, invaders_y}) &&
                    (w_col < 11'(COLS)) && (w_row < 11'(ROWS)) &&
                    (w_ox < SPR_WS) && (w_oy < SPR_HS);
  assign w_ibx = 4'(w_ox >> SCALE_LOG2);
  assign w_iby = 3'(w_oy >> SCALE_LOG2);

  proj_hit_unit #(.NUM_PROJ(NUM_PROJ)) u_proj (
    .i_px(px), .i_py(py), .i_active(proj_active), .i_owner(proj_owner),
    .i_proj_x(proj_x), .i_proj_y(proj_y), .o_laser(w_laser), .o_missile(w_missile)
  );

  // ---- stage 1: region hits, cell indices, bitmap addresses ----
  logic                r_vld_p1, r_frame_p1, r_ply_p1, r_inv_p1;
  logic [3:0]          r_pbx_p1, r_ibx_p1, r_col_p1;
  logic [2:0]          r_pby_p1, r_iby_p1, r_row_p1;
  logic [NUM_PROJ-1:0] r_laser_p1, r_missile_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1     <= 1'b0;
      r_frame_p1   <= 1'b0;
      r_ply_p1     <= 1'b0;
      r_inv_p1     <= 1'b0;
      r_pbx_p1     <= '0;
      r_pby_p1     <= '0;
      r_ibx_p1     <= '0;
      r_iby_p1     <= '0;
      r_col_p1     <= '0;
      r_row_p1     <= '0;
      r_laser_p1   <= '0;
      r_missile_p1 <= '0;
    end else begin
      r_vld_p1     <= de;
      r_frame_p1   <= frame;
      r_ply_p1     <= w_ply_in;
      r_inv_p1     <= w_inv_in;
      r_pbx_p1     <= w_pbx;
      r_pby_p1     <= w_pby;
      r_ibx_p1     <= w_ibx;
      r_iby_p1     <= w_iby;
      r_col_p1     <= 4'(w_col);
      r_row_p1     <= 3'(w_row);
      r_laser_p1   <= w_laser;
      r_missile_p1 <= w_missile;
    end
  end

  // ---- stage 2: bitmap read, priority mux, collision test ----
  logic [7:0] w_ibit;
  logic       w_alive, w_ply_lit, w_inv_lit, w_inv_coll, w_ply_coll;
  logic [7:0] w_colour;
  logic [2:0] w_slot;

  assign w_ibit    = 8'(r_row_p1) * 8'(COLS) + 8'(r_col_p1);
  assign w_alive   = |(invaders & (NI'(1) << w_ibit));
  assign w_ply_lit = r_ply_p1 && sprite_bit(SPR_PLAYER, r_pby_p1, r_pbx_p1);
  assign w_inv_lit = r_inv_p1 && w_alive && sprite_bit(SPR_INVADER, r_iby_p1, r_ibx_p1);
  assign w_inv_coll = r_vld_p1 && (|r_laser_p1) && w_inv_lit;
  assign w_ply_coll = r_vld_p1 && (|r_missile_p1) && w_ply_lit;

  always_comb begin
    w_colour = 8'h00;
    if (w_ply_lit)                    w_colour = GREEN;
    else if (|r_missile_p1)           w_colour = RED;
    else if ((|r_laser_p1) || w_inv_lit) w_colour = WHITE;
  end

  always_comb begin
    w_slot = '0;
    for (int k = NUM_PROJ - 1; k >= 0; k--)
      if (r_laser_p1[k]) w_slot = 3'(k);
  end

  logic r_frame_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_out    <= 8'h00;
      r_frame_p2 <= 1'b0;
    end else begin
      vga_out    <= r_vld_p1 ? w_colour : 8'h00;
      r_frame_p2 <= r_frame_p1;
    end
  end

  // ---- frame boundary: accumulators and report handshake ----
  logic       r_acc_inv, r_acc_ply;
  logic [2:0] r_acc_row, r_acc_proj;
  logic [3:0] r_acc_col;
  logic       w_acc_any, w_acked;

  assign w_acc_any = r_acc_inv || r_acc_ply;
  assign w_acked   = hit_ack && hit_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_inv   <= 1'b0;
      r_acc_ply   <= 1'b0;
      r_acc_row   <= '0;
      r_acc_col   <= '0;
      r_acc_proj  <= '0;
      hit_valid   <= 1'b0;
      inv_hit     <= 1'b0;
      hit_row     <= '0;
      hit_col     <= '0;
      hit_proj    <= '0;
      player_hit  <= 1'b0;
      hit_overrun <= 1'b0;
    end else if (r_frame_p2) begin
      if (w_acc_any && (!hit_valid || hit_ack)) begin
        hit_valid   <= 1'b1;
        inv_hit     <= r_acc_inv;
        hit_row     <= r_acc_row;
        hit_col     <= r_acc_col;
        hit_proj    <= r_acc_proj;
        player_hit  <= r_acc_ply;
        hit_overrun <= 1'b0;
      end else if (w_acc_any) begin
        hit_overrun <= 1'b1;
      end else if (w_acked) begin
        hit_valid   <= 1'b0;
        hit_overrun <= 1'b0;
      end
      r_acc_inv  <= 1'b0;
      r_acc_ply  <= 1'b0;
      r_acc_row  <= '0;
      r_acc_col  <= '0;
      r_acc_proj <= '0;
    end else begin
      if (w_acked) begin
        hit_valid   <= 1'b0;
        hit_overrun <= 1'b0;
      end
      // only the first laser/invader overlap of the frame is reported
      if (w_inv_coll && !r_acc_inv) begin
        r_acc_inv  <= 1'b1;
        r_acc_row  <= r_row_p1;
        r_acc_col  <= r_col_p1;
        r_acc_proj <= w_slot;
      end
      if (w_ply_coll) r_acc_ply <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: directed pixel table, handshake sequences and randomized
// frames checked against an arithmetic reference model of the compositing rules.
module tb_sprite_compositor;
  import sprite_pkg::*;

  localparam int ROWS = 5, COLS = 11, NP = 4, SC = 2, PITCH = 32;

  logic              clk, rst, de, frame, hit_ack;
  logic [9:0]        px, py, player_x, player_y, invaders_x, invaders_y;
  logic [ROWS*COLS-1:0] invaders;
  logic [NP-1:0]     proj_active, proj_owner;
  logic [NP*10-1:0]  proj_x, proj_y;
  logic [7:0]        vga_out;
  logic              hit_valid, inv_hit, player_hit, hit_overrun;
  logic [2:0]        hit_row, hit_proj;
  logic [3:0]        hit_col;

  sprite_compositor #(.ROWS(ROWS), .COLS(COLS), .NUM_PROJ(NP), .SCALE_LOG2(1),
                      .PITCH_X_LOG2(5), .PITCH_Y_LOG2(5)) dut (
    .clk(clk), .rst(rst), .px(px), .py(py), .de(de), .frame(frame),
    .player_x(player_x), .player_y(player_y), .invaders(invaders),
    .invaders_x(invaders_x), .invaders_y(invaders_y), .proj_active(proj_active),
    .proj_owner(proj_owner), .proj_x(proj_x), .proj_y(proj_y), .vga_out(vga_out),
    .hit_valid(hit_valid), .hit_ack(hit_ack), .inv_hit(inv_hit), .hit_row(hit_row),
    .hit_col(hit_col), .hit_proj(hit_proj), .player_hit(player_hit),
    .hit_overrun(hit_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit in_rect(int x, int y, int x0, int y0, int w, int h);
    return (x >= x0) && (x < x0 + w) && (y >= y0) && (y < y0 + h);
  endfunction

  function automatic bit m_player(int x, int y);
    int x0, y0;
    x0 = int'(player_x);
    y0 = int'(player_y);
    if (!in_rect(x, y, x0, y0, 16 * SC, 8 * SC)) return 1'b0;
    return PLAYER[(y - y0) / SC][15 - (x - x0) / SC];
  endfunction

  function automatic bit m_invader(int x, int y, output int row, output int col);
    int ix, iy, ox, oy;
    ix = int'(invaders_x);
    iy = int'(invaders_y);
    row = 0;
    col = 0;
    if (x < ix || y < iy) return 1'b0;
    col = (x - ix) / PITCH;
    row = (y - iy) / PITCH;
    ox  = (x - ix) % PITCH;
    oy  = (y - iy) % PITCH;
    if (col >= COLS || row >= ROWS) return 1'b0;
    if (ox >= 16 * SC || oy >= 8 * SC) return 1'b0;
    if (!invaders[row * COLS + col]) return 1'b0;
    return INVADER[oy / SC][15 - ox / SC];
  endfunction

  function automatic int m_proj(int x, int y, bit owner);
    for (int k = 0; k < NP; k++)
      if (proj_active[k] && proj_owner[k] == owner &&
          in_rect(x, y, int'(proj_x[10*k +: 10]), int'(proj_y[10*k +: 10]), PROJ_W, PROJ_H))
        return k;
    return -1;
  endfunction

  function automatic logic [7:0] m_colour(int x, int y, bit d);
    int r, c;
    if (!d) return 8'h00;
    if (m_player(x, y)) return GREEN;
    if (m_proj(x, y, 1'b1) >= 0) return RED;
    if (m_proj(x, y, 1'b0) >= 0) return WHITE;
    if (m_invader(x, y, r, c)) return WHITE;
    return 8'h00;
  endfunction

  bit m_acc_inv, m_acc_ply, rep_inv, rep_ply;
  int m_row, m_col, m_slot, rep_row, rep_col, rep_slot;

  typedef struct { logic [7:0] col; int tag; } pend_t;
  pend_t pq[$];
  int    tag_ctr = 0;

  // one pixel clock: checks the pixel driven two cycles earlier, then drives the next
  task automatic drive(input int x, input int y, input bit d, input bit f,
                       input bit use_tbl, input logic [7:0] tbl);
    pend_t e;
    int slot, r, c;
    @(negedge clk);
    if (pq.size() >= 2) begin
      e = pq.pop_front();
      chk($sformatf("vga_out#%0d", e.tag), vga_out, e.col);
    end
    px = 10'(x);
    py = 10'(y);
    de = d;
    frame = f;
    e.col = use_tbl ? tbl : m_colour(x, y, d);
    e.tag = tag_ctr++;
    pq.push_back(e);
    if (d) begin
      slot = m_proj(x, y, 1'b0);
      if (slot >= 0 && m_invader(x, y, r, c) && !m_acc_inv) begin
        m_acc_inv = 1'b1; m_row = r; m_col = c; m_slot = slot;
      end
      if (m_proj(x, y, 1'b1) >= 0 && m_player(x, y)) m_acc_ply = 1'b1;
    end
    if (f) begin
      rep_inv = m_acc_inv; rep_ply = m_acc_ply;
      rep_row = m_row; rep_col = m_col; rep_slot = m_slot;
      m_acc_inv = 1'b0; m_acc_ply = 1'b0;
    end
  endtask

  task automatic pix(input int x, input int y);
    drive(x, y, 1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // frame pulse plus the cycles until the report registers have loaded
  task automatic end_frame(input bit ack_at_boundary);
    drive(0, 0, 1'b0, 1'b1, 1'b0, 8'h00);
    idle(1);
    hit_ack = ack_at_boundary;
    idle(1);
    hit_ack = 1'b0;
    idle(1);
  endtask

  task automatic ack_report();
    hit_ack = 1'b1;
    idle(1);
    hit_ack = 1'b0;
    idle(1);
  endtask

  task automatic chk_rep(input string nm, input bit v, input bit inv, input int row,
                         input int col, input int slot, input bit ply);
    chk({nm, ".hit_valid"}, hit_valid, v);
    chk({nm, ".inv_hit"}, inv_hit, inv);
    if (inv) begin
      chk({nm, ".hit_row"}, hit_row, row);
      chk({nm, ".hit_col"}, hit_col, col);
      chk({nm, ".hit_proj"}, hit_proj, slot);
    end
    chk({nm, ".player_hit"}, player_hit, ply);
  endtask

  task automatic set_proj(input int k, input bit act, input bit own, input int x, input int y);
    proj_active[k] = act;
    proj_owner[k]  = own;
    proj_x[10*k +: 10] = 10'(x);
    proj_y[10*k +: 10] = 10'(y);
  endtask

  function automatic int clip(int v);
    return (v < 0) ? 0 : (v > 1023) ? 1023 : v;
  endfunction

  typedef struct { int x; int y; bit d; logic [7:0] exp; } vec_t;
  vec_t tbl[15];

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{132, 50, 1'b1, WHITE};
    tbl[1]  = '{100, 50, 1'b0, 8'h00};
    tbl[2]  = '{99, 50, 1'b1, 8'h00};
    tbl[3]  = '{200, 408, 1'b1, GREEN};
    tbl[4]  = '{200, 404, 1'b1, RED};
    tbl[5]  = '{102, 50, 1'b1, WHITE};
    tbl[6]  = '{104, 50, 1'b1, 8'h00};
    tbl[7]  = '{100, 210, 1'b1, 8'h00};
    tbl[8]  = '{100, 66, 1'b1, 8'h00};
    tbl[9]  = '{420, 50, 1'b1, WHITE};
    tbl[10] = '{452, 50, 1'b1, 8'h00};
    tbl[11] = '{600, 300, 1'b1, WHITE};
    tbl[12] = '{602, 300, 1'b1, 8'h00};
    tbl[13] = '{201, 411, 1'b1, GREEN};
    tbl[14] = '{199, 404, 1'b1, 8'h00};

    rst = 1'b1; de = 1'b0; frame = 1'b0; hit_ack = 1'b0; px = '0; py = '0;
    player_x = 10'd200; player_y = 10'd400;
    invaders = '1; invaders_x = 10'd100; invaders_y = 10'd50;
    proj_active = '0; proj_owner = '0; proj_x = '0; proj_y = '0;
    m_acc_inv = 0; m_acc_ply = 0; m_row = 0; m_col = 0; m_slot = 0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst.vga_out", vga_out, 0);
    chk("rst.hit_valid", hit_valid, 0);
    chk("rst.inv_hit", inv_hit, 0);
    chk("rst.hit_row", hit_row, 0);
    chk("rst.hit_col", hit_col, 0);
    chk("rst.hit_proj", hit_proj, 0);
    chk("rst.player_hit", player_hit, 0);
    chk("rst.hit_overrun", hit_overrun, 0);
    rst = 1'b0;

    // pixel table: grid at (100,50), player at (200,400), missile 2, laser 0
    set_proj(2, 1'b1, 1'b1, 200, 404);
    set_proj(0, 1'b1, 1'b0, 600, 300);
    idle(3);
    foreach (tbl[i]) drive(tbl[i].x, tbl[i].y, tbl[i].d, 1'b0, 1'b1, tbl[i].exp);
    idle(2);
    end_frame(1'b0);
    chk_rep("ply_frame", 1, 0, 0, 0, 0, 1);
    ack_report();
    chk("ply_frame.ack", hit_valid, 0);

    // dead invader, and an empty frame yields no report
    invaders[1] = 1'b0;
    idle(2);
    drive(132, 50, 1'b1, 1'b0, 1'b1, 8'h00);
    drive(100, 50, 1'b1, 1'b0, 1'b1, WHITE);
    idle(2);
    end_frame(1'b0);
    chk("empty_frame.hit_valid", hit_valid, 0);

    // laser slot 0 over invader r=2 c=3
    set_proj(0, 1'b1, 1'b0, 196, 114);
    idle(2);
    drive(196, 114, 1'b1, 1'b0, 1'b1, WHITE);
    pix(197, 115);
    idle(2);
    end_frame(1'b0);
    chk_rep("laser_hit", 1, 1, 2, 3, 0, 0);
    chk("laser_hit.overrun", hit_overrun, 0);
    ack_report();
    chk("laser_hit.ack", hit_valid, 0);

    // overrun: lowest lit slot wins; second report dropped; ack at boundary reloads
    set_proj(0, 1'b0, 1'b0, 0, 0);
    set_proj(1, 1'b1, 1'b0, 196, 114);
    set_proj(3, 1'b1, 1'b0, 196, 114);
    idle(2);
    pix(196, 114);
    idle(2);
    end_frame(1'b0);
    chk_rep("ovr_a", 1, 1, 2, 3, 1, 0);
    set_proj(1, 1'b0, 1'b0, 0, 0);
    set_proj(3, 1'b1, 1'b0, 100, 50);
    idle(2);
    pix(100, 50);
    idle(2);
    end_frame(1'b0);
    chk_rep("ovr_b", 1, 1, 2, 3, 1, 0);
    chk("ovr_b.overrun", hit_overrun, 1);
    set_proj(3, 1'b1, 1'b0, 420, 178);
    idle(2);
    pix(420, 178);
    idle(2);
    end_frame(1'b1);
    chk_rep("ovr_c", 1, 1, 4, 10, 3, 0);
    ack_report();
    chk("ovr_c.ack_valid", hit_valid, 0);
    chk("ovr_c.ack_overrun", hit_overrun, 0);

    // asynchronous reset mid-frame with a pending report and a partial accumulation
    pix(420, 178);
    idle(2);
    end_frame(1'b0);
    chk("mid_rst.pending", hit_valid, 1);
    pix(420, 178);
    idle(2);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    pq.delete();
    chk("mid_rst.vga_out", vga_out, 0);
    chk("mid_rst.hit_valid", hit_valid, 0);
    chk("mid_rst.inv_hit", inv_hit, 0);
    chk("mid_rst.hit_row", hit_row, 0);
    chk("mid_rst.hit_col", hit_col, 0);
    chk("mid_rst.hit_proj", hit_proj, 0);
    idle(2);
    end_frame(1'b0);
    chk("mid_rst.next_frame", hit_valid, 0);

    // randomized frames against the reference model
    for (int f = 0; f < 25; f++) begin
      player_x   = 10'($urandom_range(0, 1023));
      player_y   = 10'($urandom_range(0, 1023));
      invaders_x = 10'($urandom_range(0, 800));
      invaders_y = 10'($urandom_range(0, 600));
      invaders   = (ROWS*COLS)'({$urandom(), $urandom()}) | (ROWS*COLS)'({$urandom(), $urandom()});
      for (int k = 0; k < NP; k++) begin
        if ($urandom_range(0, 1) == 0)
          set_proj(k, 1'($urandom_range(0, 3) != 0), 1'b0,
                   clip(int'(invaders_x) + $urandom_range(0, COLS-1) * PITCH + $urandom_range(0, 31)),
                   clip(int'(invaders_y) + $urandom_range(0, ROWS-1) * PITCH + $urandom_range(0, 20) - 4));
        else
          set_proj(k, 1'($urandom_range(0, 3) != 0), 1'b1,
                   clip(int'(player_x) + $urandom_range(0, 36) - 4),
                   clip(int'(player_y) + $urandom_range(0, 22) - 6));
      end
      idle(2);
      for (int n = 0; n < 150; n++) begin
        int sel, x, y, k;
        sel = $urandom_range(0, 3);
        k = $urandom_range(0, NP-1);
        case (sel)
          0: begin x = int'(player_x) + $urandom_range(0, 40) - 4;
                   y = int'(player_y) + $urandom_range(0, 24) - 4; end
          1: begin x = int'(invaders_x) + $urandom_range(0, COLS*PITCH + 8) - 4;
                   y = int'(invaders_y) + $urandom_range(0, ROWS*PITCH + 8) - 4; end
          2: begin x = int'(proj_x[10*k +: 10]) + $urandom_range(0, 4) - 1;
                   y = int'(proj_y[10*k +: 10]) + $urandom_range(0, 10) - 1; end
          default: begin x = $urandom_range(0, 1023); y = $urandom_range(0, 1023); end
        endcase
        drive(clip(x), clip(y), 1'($urandom_range(0, 9) != 0), 1'b0, 1'b0, 8'h00);
      end
      idle(2);
      end_frame(1'b0);
      chk($sformatf("rnd%0d.hit_valid", f), hit_valid, rep_inv | rep_ply);
      if (rep_inv | rep_ply) begin
        chk_rep($sformatf("rnd%0d", f), 1, rep_inv, rep_row, rep_col, rep_slot, rep_ply);
        ack_report();
      end
      chk($sformatf("rnd%0d.overrun", f), hit_overrun, 0);
    end

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
